// File: rtl/arbiter_8way_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arbiter_8way_pkg;

   localparam int NUM_WAYS = 8;
   localparam int SEL_W    = 3;
   localparam int HOLD_W   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/Demux8way.sv
// 1-to-8 demux: routes the single input onto the output bit chosen by select.
module Demux8way (
   input  logic       in,
   input  logic [2:0] select,
   output logic [7:0] out
);

   assign out = {7'b0, in} << select;

endmodule

// File: rtl/arbiter_8way_rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 8.
module rr_pick8
   import arbiter_8way_pkg::*;
(
   input  logic [NUM_WAYS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    winner,
   output logic                any_req
);

   logic [SEL_W-1:0] idx;

   // Scan from the farthest offset down so the closest hit to ptr is written last.
   always_comb begin
      winner  = ptr;
      any_req = |req;
      idx     = '0;
      for (int k = NUM_WAYS - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (req[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/arbiter_8way.sv
// Two-state round-robin arbiter with hold limit; all outputs come straight from flops.
module arbiter_8way
   import arbiter_8way_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [NUM_WAYS-1:0] req,
   input  logic                done,
   output logic [NUM_WAYS-1:0] grant,
   output logic [SEL_W-1:0]    select,
   output logic                busy,
   output logic                timeout
);

   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t              state, state_nxt;
   logic [SEL_W-1:0]    ptr, ptr_nxt, winner, select_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [NUM_WAYS-1:0] grant_nxt;
   logic                any_req, busy_nxt, timeout_nxt;
   logic                hold_hit, owner_drop, release_now;

   rr_pick8 u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign hold_hit    = (hold_cnt == HOLD_LAST);
   assign owner_drop  = ~req[select];
   assign release_now = done | owner_drop | hold_hit;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)     state_nxt = GRANT;
         GRANT:   if (release_now) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_nxt   = grant;
      select_nxt  = select;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (any_req) begin
               grant_nxt  = NUM_WAYS'(1) << winner;
               select_nxt = winner;
               hold_nxt   = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_nxt   = '0;
               ptr_nxt     = select + SEL_W'(1);
               // Only a pure hold-limit release counts as a timeout; done wins ties.
               timeout_nxt = hold_hit & ~done & ~owner_drop;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: grant_nxt = '0;
      endcase
      busy_nxt = (state_nxt == GRANT);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         grant    <= '0;
         select   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         grant    <= grant_nxt;
         select   <= select_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_arbiter_8way.sv
// Randomized and directed bench for arbiter_8way against a transaction-level ownership model.
module tb_arbiter_8way;

   localparam int unsigned MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic [2:0] select;
   logic       busy;
   logic       timeout;
   logic [7:0] dmx;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, for how many cycles, and where the rotation resumes.
   int         m_owner = -1;
   int         m_ptr = 0;
   int         m_held = 0;
   logic [2:0] m_sel = 3'd0;
   logic       m_timeout = 1'b0;

   arbiter_8way #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .resetN  (resetN),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .select  (select),
      .busy    (busy),
      .timeout (timeout)
   );

   Demux8way u_dmx (
      .in     (busy),
      .select (select),
      .out    (dmx)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_grant();
      logic [7:0] one = 8'h01;
      return (m_owner < 0) ? 8'h00 : (one << m_owner);
   endfunction

   function automatic void model_reset();
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 3'd0; m_timeout = 1'b0;
   endfunction

   function automatic void model_edge(input logic [7:0] r, input logic d);
      m_timeout = 1'b0;
      if (m_owner < 0) begin
         if (r != 8'h00) begin
            for (int k = 7; k >= 0; k--)
               if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
            m_sel  = 3'(m_owner);
            m_held = 1;
         end
      end else if (d || !r[m_owner] || m_held >= int'(MAX_HOLD)) begin
         m_timeout = !d && r[m_owner];
         m_ptr     = (m_owner + 1) % 8;
         m_owner   = -1;
      end else begin
         m_held++;
      end
   endfunction

   task automatic step(input logic [7:0] r, input logic d);
      @(negedge clk);
      req = r; done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0; req = 8'h00; done = 1'b0;
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (grant !== 8'h00 || select !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: grant=%h sel=%0d busy=%b to=%b, want 00/0/0/0", grant, select, busy, timeout);
      end
      @(negedge clk); resetN = 1'b1;
      step(8'h10, 1'b0);
      checks++;
      if (grant !== 8'h10 || select !== 3'd4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_grant: grant=%h sel=%0d busy=%b, want 10/4/1", grant, select, busy);
      end
      step(8'hFF, 1'b0);
      #2 resetN = 1'b0;
      #1;
      checks++;
      if (grant !== 8'h00 || busy !== 1'b0 || select !== 3'd0 || timeout !== 1'b0 || dmx !== 8'h00) begin
         errors++;
         $display("FAIL reset_async: grant=%h sel=%0d busy=%b to=%b dmx=%h, want all zero", grant, select, busy, timeout, dmx);
      end
      model_reset();
      @(negedge clk); resetN = 1'b1;
      step(8'hFF, 1'b0);
      checks++;
      if (grant !== 8'h01 || select !== 3'd0) begin
         errors++;
         $display("FAIL reset_first_arb: grant=%h sel=%0d, want 01/0", grant, select);
      end
   endtask

   task automatic test_round_robin();
      int   k = 0;
      logic prev_busy = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 40 && k < 9; cyc++) begin
         step(8'hFF, m_owner >= 0);
         checks++;
         if (grant !== exp_grant() || select !== m_sel || busy !== (m_owner >= 0) || timeout !== m_timeout || dmx[select] !== busy) begin
            errors++;
            $display("FAIL rr c%0d: grant=%h sel=%0d busy=%b to=%b, want %h/%0d/%b/%b", cyc, grant, select, busy, timeout, exp_grant(), m_sel, m_owner >= 0, m_timeout);
         end
         if (busy && !prev_busy) begin
            checks++;
            if (select !== 3'(k % 8)) begin
               errors++;
               $display("FAIL rr_seq #%0d: sel=%0d, want %0d", k, select, k % 8);
            end
            k++;
         end
         prev_busy = busy;
      end
      checks++;
      if (k != 9) begin
         errors++;
         $display("FAIL rr_count: grants=%0d, want 9", k);
      end
   endtask

   task automatic test_skip_wrap();
      do_reset();
      step(8'h20, 1'b0);
      step(8'h20, 1'b1);
      step(8'h03, 1'b0);
      checks++;
      if (grant !== 8'h01 || select !== 3'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL skip_wrap: grant=%h sel=%0d busy=%b, want 01/0/1", grant, select, busy);
      end
   endtask

   task automatic test_timeout();
      int gcnt = 0;
      int after = -1;
      do_reset();
      for (int cyc = 0; cyc < 12; cyc++) begin
         step(8'h08, 1'b0);
         checks++;
         if (grant !== exp_grant() || select !== m_sel || busy !== (m_owner >= 0) || timeout !== m_timeout || dmx[select] !== busy) begin
            errors++;
            $display("FAIL timeout c%0d: grant=%h sel=%0d busy=%b to=%b, want %h/%0d/%b/%b", cyc, grant, select, busy, timeout, exp_grant(), m_sel, m_owner >= 0, m_timeout);
         end
         if (after < 0 && timeout) after = cyc;
         else if (after < 0 && grant == 8'h08) gcnt++;
         if (after >= 0 && cyc == after + 1) begin
            checks++;
            if (grant !== 8'h08 || select !== 3'd3) begin
               errors++;
               $display("FAIL timeout_regrant: grant=%h sel=%0d, want 08/3", grant, select);
            end
         end
      end
      checks++;
      if (gcnt != 4 || after < 0) begin
         errors++;
         $display("FAIL timeout_hold: held=%0d pulse_at=%0d, want held 4 with a pulse", gcnt, after);
      end
   endtask

   task automatic test_requester_drop();
      do_reset();
      step(8'h02, 1'b0);
      step(8'hFD, 1'b0);
      checks++;
      if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL drop_release: grant=%h busy=%b to=%b, want 00/0/0", grant, busy, timeout);
      end
      step(8'hFF, 1'b0);
      checks++;
      if (grant !== 8'h04 || select !== 3'd2) begin
         errors++;
         $display("FAIL drop_ptr: grant=%h sel=%0d, want 04/2", grant, select);
      end
   endtask

   task automatic test_tie();
      do_reset();
      for (int cyc = 0; cyc < 4; cyc++) step(8'h01, 1'b0);
      step(8'h01, 1'b1);
      checks++;
      if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL tie: grant=%h busy=%b to=%b, want 00/0/0", grant, busy, timeout);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       d;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         r = 8'($urandom) & 8'($urandom) & 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         d = ($urandom_range(0, 5) == 0);
         step(r, d);
         checks++;
         if (grant !== exp_grant() || select !== m_sel || busy !== (m_owner >= 0) || timeout !== m_timeout || dmx[select] !== busy) begin
            errors++;
            $display("FAIL random c%0d req=%h done=%b: grant=%h sel=%0d busy=%b to=%b, want %h/%0d/%b/%b", cyc, r, d, grant, select, busy, timeout, exp_grant(), m_sel, m_owner >= 0, m_timeout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_skip_wrap();
      test_timeout();
      test_requester_drop();
      test_tie();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbiter_8way.md
ARBITER_8WAY -- requirements
Module: arbiter_8way

Interface
REQ-001 Parameter MAX_HOLD, default 16, range 1..255: maximum cycles one grant may be held before forced release.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request lines; bit i = requester i (A..H order, bit 0 = A).
REQ-005 done  input  1  owner releases the resource; sampled only in GRANT.
REQ-006 grant  output  8  one-hot grant, registered; all-zero when no owner.
REQ-007 select  output  3  binary index of current owner, drives the 8-way demux select; registered.
REQ-008 busy  output  1  high while in GRANT.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.

Function
REQ-010 FSM SHALL have exactly two states: IDLE, GRANT.
REQ-011 IDLE: if req == 0, stay IDLE; grant=0, busy=0, select holds last value.
REQ-012 IDLE with req != 0: winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8); next edge: grant=onehot(winner), select=winner, busy=1, state GRANT, holdCnt=0.
REQ-013 Grant latency SHALL be exactly 1 cycle from the edge at which req is sampled in IDLE.
REQ-014 GRANT: holdCnt increments by 1 per cycle, saturating at MAX_HOLD.
REQ-015 GRANT exits on the first edge where any of: done=1, req[select]=0, or holdCnt==MAX_HOLD-1.
REQ-016 On exit: grant=0, busy=0, state IDLE, ptr=(select+1) mod 8 (3-bit wrap, 7 -> 0).
REQ-017 timeout SHALL pulse for exactly the cycle after exit only when exit is caused by holdCnt alone (done=0 and req[select]=1).
REQ-018 Simultaneous done and timeout condition: treated as done; no timeout pulse.
REQ-019 After any exit, at least one IDLE cycle SHALL occur before the next grant (one-cycle bubble, no back-to-back grants).
REQ-020 grant SHALL never have more than one bit set; grant[select]==busy at all times after reset.
REQ-021 Changes on req bits other than req[select] during GRANT SHALL have no effect until IDLE.
REQ-022 done asserted in IDLE SHALL be ignored.

Reset
REQ-023 resetN low SHALL immediately (no clock) force: state IDLE, grant=0, select=0, busy=0, timeout=0, ptr=0, holdCnt=0.
REQ-024 Reset asserted mid-GRANT SHALL drop grant asynchronously; ptr returns to 0 (no fairness history retained).
REQ-025 First arbitration after reset release SHALL use ptr=0 (A highest priority).

Structure
REQ-026 Shared package holds: state encoding constants (IDLE=0, GRANT=1), NUM_WAYS=8, SEL_W=3.
REQ-027 One sub-module: rr_pick8 -- combinational round-robin priority picker (inputs req, ptr; outputs winner index, anyReq).
REQ-028 All outputs driven directly from flops; no combinational path from inputs to outputs.
REQ-029 RTL target 120-400 lines; bench instantiates arbiter_8way driving a Demux8way with select and in=busy.

Verification
REQ-030 Reset: resetN=0 mid-GRANT with req=8'hFF -> grant=0, busy=0, select=0 immediately without clock edge.
REQ-031 Round-robin: req=8'hFF held, done pulsed 1 cycle after each grant -> select sequence 0,1,2,...,7,0; each grant separated by one IDLE cycle.
REQ-032 Skip/wrap: ptr=6 (after granting 5), req=8'b0000_0011 -> next grant=8'b0000_0001, select=0.
REQ-033 Timeout: MAX_HOLD=4, req=8'h08, done=0 -> grant=8'h08 for 4 cycles, then grant=0 with timeout=1 for 1 cycle, regrant select=3 after bubble.
REQ-034 Requester drop: grant to B (8'h02), req[1] deasserted -> grant=0 next edge, timeout=0, ptr=2.
REQ-035 Tie: done=1 on the same edge as holdCnt==MAX_HOLD-1 -> release, timeout stays 0; demux output at select matches busy throughout all scenarios.
